tick_up_counter: RTL and testbench
==================================

Name: tick_up_counter

Overview:
- Free-running, prescaled binary up-counter: divides the system clock by TIME, then advances a WIDTH-bit count once per prescaler period.
- Complements the team's existing 1 Hz down-counter.
- Drives LED/7-seg display logic.
- Exposes tick and terminal-count pulses so instances can be cascaded (seconds -> minutes) and downstream logic can synchronise to count updates.

Parameters:
- TIME, 50000000: prescaler divisor in clk cycles (50 MHz board clock -> 1 Hz). Must be >= 2.
- WIDTH, 3: count width in bits.
- MAX, 7: highest count value before wrap. Must be <= 2^WIDTH-1 and >= 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable (level). Prescaler and count freeze when low.
- clr  input  1  synchronous clear pulse: prescaler and count to 0.
- load  input  1  synchronous load pulse.
- load_val  input  WIDTH  value loaded into y on load.
- y  output  WIDTH  current count, registered.
- tick  output  1  one-cycle pulse, coincident with every y update from counting.
- tc  output  1  one-cycle pulse, coincident with y wrapping MAX -> 0.
- ovf  output  1  sticky flag, set on first wrap, cleared only by rst or clr.

Behaviour:
- Prescaler cnt: internal, width $clog2(TIME), range 0..TIME-1.
- Reset (rst=1 at clock edge): cnt=0, y=0, tick=0, tc=0, ovf=0. Reset mid-period discards partial prescaler progress.
- Priority per edge: rst > clr > load > count.
- clr=1: cnt=0, y=0, ovf=0, tick=0, tc=0.
- load=1 (clr=0):
  - y=load_val, clamped to MAX if load_val > MAX.
  - cnt=0, so a full TIME period elapses before the next increment.
  - tick=0, tc=0. ovf unchanged.
- Count, en=1, no clr/load:
  - If cnt==TIME-1: cnt<=0 and tick<=1.
    - If y==MAX: y<=0, tc<=1, ovf<=1.
    - Otherwise: y<=y+1.
  - Otherwise: cnt<=cnt+1, tick<=0, tc<=0.
- en=0: cnt and y hold. tick=0, tc=0.
  - Pausing with cnt==TIME-1 and resuming later produces the tick on the first enabled edge.
- Timing:
  - tick/tc are registered: high in exactly the cycle in which the new y is visible. Never high for two consecutive cycles unless TIME==1, which is disallowed.
  - From the first enabled edge after rst release, the first tick appears TIME edges later, with y=1.
- Wrap period: tc pulses once every (MAX+1)*TIME enabled cycles.
- Cascading: feed a lower instance's tc into a higher instance's en with TIME=1-equivalent behaviour. Not supported directly; chain via tc -> en with TIME=2 is not exact. Cascading is done by upper instance en=tc of lower plus upper TIME=1 variant, handled in the wrapper, out of scope here.
- All arithmetic is unsigned, modulo MAX+1 for y. No combinational path from inputs to outputs.

Optional Feature:
- Macro: TICK_DOWN_MODE_EN.
- Defined:
  - Adds input port dir (1 bit, after en).
  - dir=0: count up, as above.
  - dir=1: on prescaler wrap, y<=y-1. If y==0: y<=MAX, tc<=1, ovf<=1.
  - dir is sampled only on the counting edge. Changing dir mid-period does not reset cnt.
- Not defined: dir port absent, up-count only. Behaviour identical to dir=0.

Test Plan:
- Reset/first tick (TIME=4, MAX=7): rst 2 cycles, then en=1 -> y=0, tick=0 for 3 edges; tick=1 with y=1 on the 4th edge; y=2 on the 8th edge.
- Wrap (TIME=4, MAX=5): run 24 enabled cycles -> y sequence 1..5,0; tc=1 and ovf=1 exactly on the edge y becomes 0; tc=0 on the next cycle, ovf stays 1.
- Pause (TIME=4): en=1 for 6 cycles (y=1, cnt=2), en=0 for 10 cycles, en=1 -> y held at 1, no tick during pause; next tick after 2 more enabled edges, y=2.
- Load/clamp (MAX=5, WIDTH=3): load=1 with load_val=7 -> y=5; next tick after 4 edges gives y=0, tc=1. load_val=3 -> y=3, ovf unchanged.
- Priority: assert clr and load together with load_val=4 while cnt==TIME-1 -> y=0, tick=0, tc=0, ovf=0. Then rst together with load -> all outputs 0.
- With TICK_DOWN_MODE_EN, dir=1, MAX=7, TIME=4: from reset, first tick -> y=7 and tc=1; subsequent ticks 6,5,...

Source files
------------

// File: rtl/tick_up_counter.sv
// Prescaled free-running counter: divides clk by TIME, then advances y through 0..MAX once per period.
// Optional down-count mode with a dir input when TICK_DOWN_MODE_EN is defined.
module tick_up_counter #(
  parameter int TIME  = 50000000,
  parameter int WIDTH = 3,
  parameter int MAX   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef TICK_DOWN_MODE_EN
  input  logic             dir,
`endif
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] y,
  output logic             tick,
  output logic             tc,
  output logic             ovf
);

  localparam int CW = (TIME > 1) ? $clog2(TIME) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(TIME - 1);
  localparam logic [WIDTH-1:0] Y_MAX    = WIDTH'(MAX);

  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic             tick_reg, tick_next;
  logic             tc_reg, tc_next;
  logic             ovf_reg, ovf_next;
  logic             down;

`ifdef TICK_DOWN_MODE_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  // tick/tc are computed one edge early so they line up with the new y value.
  always_comb begin
    cnt_next  = cnt_reg;
    y_next    = y_reg;
    tick_next = 1'b0;
    tc_next   = 1'b0;
    ovf_next  = ovf_reg;
    if (clr) begin
      cnt_next = '0;
      y_next   = '0;
      ovf_next = 1'b0;
    end else if (load) begin
      cnt_next = '0;
      y_next   = (load_val > Y_MAX) ? Y_MAX : load_val;
    end else if (en) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_next  = '0;
        tick_next = 1'b1;
        if (down) begin
          if (y_reg == '0) begin
            y_next   = Y_MAX;
            tc_next  = 1'b1;
            ovf_next = 1'b1;
          end else begin
            y_next = y_reg - 1'b1;
          end
        end else begin
          if (y_reg == Y_MAX) begin
            y_next   = '0;
            tc_next  = 1'b1;
            ovf_next = 1'b1;
          end else begin
            y_next = y_reg + 1'b1;
          end
        end
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      y_reg    <= '0;
      tick_reg <= 1'b0;
      tc_reg   <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      y_reg    <= y_next;
      tick_reg <= tick_next;
      tc_reg   <= tc_next;
      ovf_reg  <= ovf_next;
    end
  end

  assign y    = y_reg;
  assign tick = tick_reg;
  assign tc   = tc_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_tick_up_counter.sv
// Directed bench for tick_up_counter with TIME=4, WIDTH=3, MAX=5.
// Covers reset, first tick, wrap, pause, load clamp, priority and (if enabled) down mode.
module tb_tick_up_counter;

  localparam int TIME  = 4;
  localparam int WIDTH = 3;
  localparam int MAX   = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             dir;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] y;
  logic             tick;
  logic             tc;
  logic             ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tick_up_counter #(.TIME(TIME), .WIDTH(WIDTH), .MAX(MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
`ifdef TICK_DOWN_MODE_EN
    .dir      (dir),
`endif
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .y        (y),
    .tick     (tick),
    .tc       (tc),
    .ovf      (ovf)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int ey, input int etick, input int etc, input int eovf);
    check({tag, ".y"}, int'(y), ey);
    check({tag, ".tick"}, int'(tick), etick);
    check({tag, ".tc"}, int'(tc), etc);
    check({tag, ".ovf"}, int'(ovf), eovf);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
    step(); step();
    check_all("reset", 0, 0, 0, 0);

    // First tick TIME edges after enabling.
    rst = 1'b0; en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i % TIME == 0) check_all($sformatf("first_tick.%0d", i), i / TIME, 1, 0, 0);
      else               check_all($sformatf("first_tick.%0d", i), i / TIME, 0, 0, 0);
    end

    // Wrap: 24 enabled cycles after a clear, y runs 1..5,0.
    clr = 1'b1; step(); clr = 1'b0;
    check_all("clr", 0, 0, 0, 0);
    for (int i = 1; i <= 24; i++) begin
      step();
      check_all($sformatf("wrap.%0d", i), (i / TIME) % (MAX + 1),
                (i % TIME == 0) ? 1 : 0, (i == 24) ? 1 : 0, (i == 24) ? 1 : 0);
    end
    step();
    check_all("wrap.after", 0, 0, 0, 1);

    // Pause mid-period, then resume.
    clr = 1'b1; step(); clr = 1'b0;
    check_all("clr2", 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) step();
    check_all("pause.pre", 1, 0, 0, 0);
    en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      check_all($sformatf("pause.%0d", i), 1, 0, 0, 0);
    end
    en = 1'b1;
    step();
    check_all("resume.1", 1, 0, 0, 0);
    step();
    check_all("resume.2", 2, 1, 0, 0);

    // Load with clamp, then count to wrap.
    load = 1'b1; load_val = 3'd7; step(); load = 1'b0;
    check_all("load_clamp", 5, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check_all($sformatf("load_run.%0d", i), 5, 0, 0, 0);
    end
    step();
    check_all("load_wrap", 0, 1, 1, 1);
    load = 1'b1; load_val = 3'd3; step(); load = 1'b0;
    check_all("load3", 3, 0, 0, 1);

    // clr beats load while the prescaler is at its last count.
    step(); step(); step();
    check_all("prio.pre", 3, 0, 0, 1);
    clr = 1'b1; load = 1'b1; load_val = 3'd4; step(); clr = 1'b0; load = 1'b0;
    check_all("prio.clr_load", 0, 0, 0, 0);
    load = 1'b1; step(); load = 1'b0;
    check_all("prio.load4", 4, 0, 0, 0);
    rst = 1'b1; load = 1'b1; step(); rst = 1'b0; load = 1'b0;
    check_all("prio.rst_load", 0, 0, 0, 0);

`ifdef TICK_DOWN_MODE_EN
    // Down mode from reset: first tick wraps 0 -> MAX.
    dir = 1'b1; en = 1'b1;
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 4)       check_all("down.4", 5, 1, 1, 1);
      else if (i == 8)  check_all("down.8", 4, 1, 0, 1);
      else if (i == 12) check_all("down.12", 3, 1, 0, 1);
      else              check({"down.tick", $sformatf("%0d", i)}, int'(tick), 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
